// File: rtl/br_arb_rr_pkt_pkg.sv
// Shared types for the packet-locking round-robin merge.
package br_arb_rr_pkt_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/br_arb_rr.sv
// Round-robin arbiter: combinational grant, priority pointer moves past update_grant on update.
module br_arb_rr #(
  parameter int NumRequesters = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NumRequesters-1:0] request,
  input  logic                     enable_priority_update,
  input  logic [NumRequesters-1:0] update_grant,
  output logic [NumRequesters-1:0] grant
);

  localparam int PtrW = $clog2(NumRequesters);

  // ptr_q holds the index of the highest-priority requester.
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_next;
  logic            found;

  // Pick the requesting index with the smallest circular distance from ptr_q.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int d = 0; d < NumRequesters; d++) begin
      for (int i = 0; i < NumRequesters; i++) begin
        if (!found && request[i] &&
            (((i - int'(ptr_q) + NumRequesters) % NumRequesters) == d)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // update_grant may differ from grant while the caller holds a lock.
  always_comb begin
    ptr_next = ptr_q;
    for (int i = 0; i < NumRequesters; i++) begin
      if (update_grant[i]) begin
        ptr_next = (i == NumRequesters - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (enable_priority_update) begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/br_arb_rr_pkt.sv
// Merges packets from several requesters onto one stream; a packet is never interleaved.
module br_arb_rr_pkt
  import br_arb_rr_pkt_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int Width         = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NumRequesters-1:0]       in_valid,
  output logic [NumRequesters-1:0]       in_ready,
  input  logic [NumRequesters-1:0]       in_last,
  input  logic [NumRequesters*Width-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [Width-1:0]               out_data,
  output logic [NumRequesters-1:0]       out_grant
);

  // Handshake: a beat moves when out_valid && out_ready; in_ready mirrors out_ready
  // only for the granted requester, so exactly that requester sees its beat accepted.

  if (NumRequesters < 2) begin : g_bad_num_requesters
    $error("br_arb_rr_pkt: NumRequesters must be >= 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("br_arb_rr_pkt: Width must be >= 1");
  end

  lock_state_e              state_q;
  logic [NumRequesters-1:0] owner_q;
  logic [NumRequesters-1:0] rr_grant;
  logic [NumRequesters-1:0] grant_sel;
  logic                     xfer;
  logic                     prio_update;

  assign prio_update = xfer && out_last;

  br_arb_rr #(
    .NumRequesters(NumRequesters)
  ) u_rr (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .request               (in_valid),
    .enable_priority_update(prio_update),
    .update_grant          (grant_sel),
    .grant                 (rr_grant)
  );

  assign grant_sel = (state_q == LOCKED) ? owner_q : rr_grant;

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant_sel[i]) begin
        out_data = in_data[i*Width +: Width];
        out_last = in_last[i];
      end
    end
  end

  assign out_grant = grant_sel;
  assign out_valid = |(in_valid & grant_sel);
  assign in_ready  = grant_sel & {NumRequesters{out_ready}};
  assign xfer      = out_valid && out_ready;

  // Lock on a non-final beat taken while arbitrating; release when the owner's last beat moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
    end else if (xfer) begin
      if (state_q == UNLOCKED && !out_last) begin
        state_q <= LOCKED;
        owner_q <= grant_sel;
      end else if (state_q == LOCKED && out_last) begin
        state_q <= UNLOCKED;
        owner_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_br_arb_rr_pkt.sv
// Directed bench for br_arb_rr_pkt with three requesters and byte payloads.
module tb_br_arb_rr_pkt;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_grant;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] obs;
  logic [15:0] exp_v;

  br_arb_rr_pkt #(.NumRequesters(N), .Width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_data (out_data),
    .out_grant(out_grant)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic r);
    in_valid  = v;
    in_last   = l;
    in_data   = {d2, d1, d0};
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scenarios: inputs applied 1 time unit after the edge, outputs sampled 1 unit later.
  task automatic test_reset();
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b0, 1'b0, 3'b000, 3'b000, 8'h00};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
    tick();
    drive(3'b111, 3'b111, 8'h10, 8'h11, 8'h12, 1'b1);
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b1, 1'b1, 3'b001, 3'b001, 8'h10};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_busy: got %h want %h", obs, exp_v); end
    tick();
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [15:0] tbl [4];
    tbl[0] = {1'b1, 1'b1, 3'b001, 3'b001, 8'h10};
    tbl[1] = {1'b1, 1'b1, 3'b010, 3'b010, 8'h11};
    tbl[2] = {1'b1, 1'b1, 3'b100, 3'b100, 8'h12};
    tbl[3] = {1'b1, 1'b1, 3'b001, 3'b001, 8'h10};
    tick();
    drive(3'b111, 3'b111, 8'h10, 8'h11, 8'h12, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      obs = {out_valid, out_last, out_grant, in_ready, out_data};
      n_cmp++;
      if (obs !== tbl[k]) begin n_bad++; $display("FAIL rr_cycle%0d: got %h want %h", k, obs, tbl[k]); end
      tick();
    end
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_packet();
    logic [15:0] tbl [4];
    tbl[0] = {1'b1, 1'b0, 3'b010, 3'b010, 8'hAA};
    tbl[1] = {1'b1, 1'b0, 3'b010, 3'b010, 8'hBB};
    tbl[2] = {1'b1, 1'b1, 3'b010, 3'b010, 8'hCC};
    tbl[3] = {1'b1, 1'b1, 3'b100, 3'b000, 8'h02};
    tick();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(3'b111, 3'b101, 8'h01, 8'hAA, 8'h02, 1'b1);
        1: drive(3'b111, 3'b101, 8'h01, 8'hBB, 8'h02, 1'b1);
        2: drive(3'b111, 3'b111, 8'h01, 8'hCC, 8'h02, 1'b1);
        default: drive(3'b111, 3'b111, 8'h01, 8'hCC, 8'h02, 1'b0);
      endcase
      #1;
      obs = {out_valid, out_last, out_grant, in_ready, out_data};
      n_cmp++;
      if (obs !== tbl[k]) begin n_bad++; $display("FAIL pkt_beat%0d: got %h want %h", k, obs, tbl[k]); end
      if (k < 3) tick();
    end
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_bubble();
    logic [15:0] tbl [5];
    tbl[0] = {1'b1, 1'b0, 3'b001, 3'b001, 8'h30};
    tbl[1] = {1'b0, 1'b0, 3'b001, 3'b001, 8'h30};
    tbl[2] = {1'b0, 1'b0, 3'b001, 3'b001, 8'h30};
    tbl[3] = {1'b1, 1'b1, 3'b001, 3'b001, 8'h31};
    tbl[4] = {1'b1, 1'b1, 3'b010, 3'b000, 8'h35};
    tick();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(3'b001, 3'b000, 8'h30, 8'h35, 8'h00, 1'b1);
        1, 2: drive(3'b010, 3'b010, 8'h30, 8'h35, 8'h00, 1'b1);
        3: drive(3'b011, 3'b011, 8'h31, 8'h35, 8'h00, 1'b1);
        default: drive(3'b010, 3'b010, 8'h31, 8'h35, 8'h00, 1'b0);
      endcase
      #1;
      obs = {out_valid, out_last, out_grant, in_ready, out_data};
      n_cmp++;
      if (obs !== tbl[k]) begin n_bad++; $display("FAIL bubble_cycle%0d: got %h want %h", k, obs, tbl[k]); end
      if (k < 4) tick();
    end
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_stall();
    logic [15:0] tbl [8];
    tbl[0] = {1'b1, 1'b0, 3'b100, 3'b100, 8'h40};
    for (int k = 1; k < 5; k++) tbl[k] = {1'b1, 1'b0, 3'b100, 3'b000, 8'h41};
    tbl[5] = {1'b1, 1'b0, 3'b100, 3'b100, 8'h41};
    tbl[6] = {1'b1, 1'b1, 3'b100, 3'b100, 8'h42};
    tbl[7] = {1'b1, 1'b1, 3'b001, 3'b000, 8'h01};
    tick();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(3'b100, 3'b000, 8'h00, 8'h00, 8'h40, 1'b1);
        1, 2, 3, 4: drive(3'b111, 3'b011, 8'h01, 8'h02, 8'h41, 1'b0);
        5: drive(3'b111, 3'b011, 8'h01, 8'h02, 8'h41, 1'b1);
        6: drive(3'b111, 3'b111, 8'h01, 8'h02, 8'h42, 1'b1);
        default: drive(3'b111, 3'b111, 8'h01, 8'h02, 8'h42, 1'b0);
      endcase
      #1;
      obs = {out_valid, out_last, out_grant, in_ready, out_data};
      n_cmp++;
      if (obs !== tbl[k]) begin n_bad++; $display("FAIL stall_cycle%0d: got %h want %h", k, obs, tbl[k]); end
      if (k < 7) tick();
    end
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_packet();
    tick();
    drive(3'b100, 3'b000, 8'h00, 8'h00, 8'h50, 1'b1);
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b1, 1'b0, 3'b100, 3'b100, 8'h50};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_first: got %h want %h", obs, exp_v); end
    tick();
    drive(3'b111, 3'b011, 8'h60, 8'h61, 8'h51, 1'b1);
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b1, 1'b0, 3'b100, 3'b100, 8'h51};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_locked: got %h want %h", obs, exp_v); end
    #1;
    rst_n = 1'b0;
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b1, 1'b1, 3'b001, 3'b001, 8'h60};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_during: got %h want %h", obs, exp_v); end
    tick();
    rst_n = 1'b1;
    #1;
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_after: got %h want %h", obs, exp_v); end
    tick();
    obs = {out_valid, out_last, out_grant, in_ready, out_data};
    exp_v = {1'b1, 1'b1, 3'b010, 3'b010, 8'h61};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_next: got %h want %h", obs, exp_v); end
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
  endtask

  // Sequence and final report
  initial begin
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    test_reset();
    test_round_robin();
    test_packet();
    test_bubble();
    test_stall();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
